// File: rtl/cbq_tag_recycler_pkg.sv
// cbq_tag_recycler_pkg: shared size defaults and recycler state encoding
package cbq_tag_recycler_pkg;
  localparam int TAGWIDE_DEF = 5;
  localparam int INFLDEEP_DEF = 8;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, CLEAN = 2'd2} state_t;
endpackage

// File: rtl/cbq_tag_recycler_cam.sv
// cbq_tag_cam: tag-to-index match over valid ring entries, lowest index wins
module cbq_tag_cam
  import cbq_tag_recycler_pkg::*;
#(
  parameter int TAGWIDE = TAGWIDE_DEF,
  parameter int INFLDEEP = INFLDEEP_DEF
) (
  input  logic [INFLDEEP-1:0]              vld,
  input  logic [INFLDEEP-1:0][TAGWIDE-1:0] tags,
  input  logic [TAGWIDE-1:0]               key,
  output logic                             hit,
  output logic [$clog2(INFLDEEP)-1:0]      idx
);
  localparam int PW = $clog2(INFLDEEP);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = INFLDEEP - 1; i >= 0; i--)
      if (vld[i] && tags[i] == key) begin
        hit = 1'b1;
        idx = i[PW-1:0];
      end
  end
endmodule

// File: rtl/cbq_tag_recycler.sv
// cbq_tag_recycler: in-flight checkpoint tag ring that retires, flushes and returns tags to the free queue.
// Defining CBQ_RECYCLE_PERF_EN adds saturating retire/flush return counters.
module cbq_tag_recycler
  import cbq_tag_recycler_pkg::*;
#(
  parameter int TAGWIDE = TAGWIDE_DEF,
  parameter int INFLDEEP = INFLDEEP_DEF
) (
  input  logic                          Clk,
  input  logic                          Rest,
  input  logic                          AllocValid,
  input  logic [TAGWIDE-1:0]            AllocTag,
  output logic                          AllocReady,
  input  logic                          ResolveValid,
  input  logic [TAGWIDE-1:0]            ResolveTag,
  input  logic                          ResolveMiss,
  input  logic                          GlobalFlush,
  input  logic                          FreeFull,
  output logic                          FreeWable,
  output logic [TAGWIDE-1:0]            FreeDin,
  output logic                          FreeClean,
  output logic [$clog2(INFLDEEP):0]     InflightCnt,
`ifdef CBQ_RECYCLE_PERF_EN
  output logic [15:0]                   PerfRetireCnt,
  output logic [15:0]                   PerfFlushCnt,
`endif
  output logic                          Busy
);
  localparam int PW = $clog2(INFLDEEP);
  localparam int CW = PW + 1;
  state_t state, state_nx;
  logic [INFLDEEP-1:0] vld, dn;
  logic [INFLDEEP-1:0][TAGWIDE-1:0] tags;
  logic [PW-1:0] head, tail, tgt, tgt_nx, tail_m1, tail_run, hit_idx, hit_p1, hit_age, tgt_age;
  logic [CW-1:0] cnt;
  logic hit, push, ret, pop, res_ok, miss_new;
  cbq_tag_cam #(.TAGWIDE(TAGWIDE), .INFLDEEP(INFLDEEP)) u_cam (
    .vld(vld), .tags(tags), .key(ResolveTag), .hit(hit), .idx(hit_idx)
  );
  assign tail_m1 = tail - PW'(1);
  assign tail_run = tail + PW'(push);
  assign hit_p1 = hit_idx + PW'(1);
  assign hit_age = hit_idx - head;
  assign tgt_age = tgt - head;
  // while flushing, only entries at or older than the target are still alive
  assign res_ok = ResolveValid && hit && (state == RUN || hit_age <= tgt_age);
  assign miss_new = res_ok && ResolveMiss && (state == RUN || hit_age < tgt_age);
  assign tgt_nx = miss_new ? hit_idx : tgt;
  always_ff @(posedge Clk or posedge Rest)
    if (Rest) state <= RUN;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (GlobalFlush) state_nx = CLEAN;
    else if (state == CLEAN) state_nx = RUN;
    else if (state == RUN) state_nx = miss_new && tail_run != hit_p1 ? FLUSH : RUN;
    else if (pop) state_nx = tail_m1 == tgt_nx + PW'(1) ? RUN : FLUSH;
  end
  always_comb begin
    AllocReady = state == RUN && cnt < CW'(INFLDEEP);
    push = AllocValid && AllocReady && !GlobalFlush;
    pop = state == FLUSH && !FreeFull && !GlobalFlush;
    ret = state == RUN && vld[head] && dn[head] && !FreeFull && !GlobalFlush;
    FreeWable = pop || ret;
    FreeDin = pop ? tags[tail_m1] : ret ? tags[head] : '0;
    FreeClean = state == CLEAN;
    InflightCnt = cnt;
    Busy = state != RUN;
  end
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      vld <= '0;
      dn <= '0;
      tags <= '0;
      head <= '0;
      tail <= '0;
      tgt <= '0;
      cnt <= '0;
    end else if (GlobalFlush) begin
      vld <= '0;
      dn <= '0;
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (res_ok) dn[hit_idx] <= 1'b1;
      if (push) begin
        vld[tail] <= 1'b1;
        dn[tail] <= 1'b0;
        tags[tail] <= AllocTag;
      end
      if (ret) begin
        vld[head] <= 1'b0;
        dn[head] <= 1'b0;
      end
      if (pop) begin
        vld[tail_m1] <= 1'b0;
        dn[tail_m1] <= 1'b0;
      end
      head <= head + PW'(ret);
      tail <= pop ? tail_m1 : tail_run;
      cnt <= cnt + CW'(push) - CW'(ret) - CW'(pop);
      tgt <= tgt_nx;
    end
  end
`ifdef CBQ_RECYCLE_PERF_EN
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      PerfRetireCnt <= '0;
      PerfFlushCnt <= '0;
    end else begin
      if (ret && !(&PerfRetireCnt)) PerfRetireCnt <= PerfRetireCnt + 16'd1;
      if (pop && !(&PerfFlushCnt)) PerfFlushCnt <= PerfFlushCnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cbq_tag_recycler.sv
// tb_cbq_tag_recycler: directed scenarios plus random traffic checked against a queue-based ring model
module tb_cbq_tag_recycler;
  logic Clk = 1'b0;
  logic Rest, AllocValid, AllocReady, ResolveValid, ResolveMiss, GlobalFlush, FreeFull;
  logic FreeWable, FreeClean, Busy;
  logic [4:0] AllocTag, ResolveTag, FreeDin;
  logic [3:0] InflightCnt;
`ifdef CBQ_RECYCLE_PERF_EN
  logic [15:0] PerfRetireCnt, PerfFlushCnt;
`endif
  typedef struct {logic [4:0] tag; bit done;} ent_t;
  ent_t q[$];
  int mode, tgt, n_chk, n_fail;
  always #5 Clk = ~Clk;
  cbq_tag_recycler dut (
    .Clk(Clk), .Rest(Rest), .AllocValid(AllocValid), .AllocTag(AllocTag), .AllocReady(AllocReady),
    .ResolveValid(ResolveValid), .ResolveTag(ResolveTag), .ResolveMiss(ResolveMiss),
    .GlobalFlush(GlobalFlush), .FreeFull(FreeFull), .FreeWable(FreeWable), .FreeDin(FreeDin),
    .FreeClean(FreeClean), .InflightCnt(InflightCnt),
`ifdef CBQ_RECYCLE_PERF_EN
    .PerfRetireCnt(PerfRetireCnt), .PerfFlushCnt(PerfFlushCnt),
`endif
    .Busy(Busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [4:0] fresh();
    logic [4:0] t;
    bit used;
    do begin
      t = 5'($urandom);
      used = 0;
      foreach (q[i]) if (q[i].tag == t) used = 1;
    end while (used);
    return t;
  endfunction
  task automatic model_reset();
    q.delete();
    mode = 0;
    tgt = 0;
  endtask
  // mode 0 = running, 1 = unwinding younger entries, 2 = free-queue clean pulse
  task automatic step(input logic av, input logic [4:0] at, input logic rv, input logic [4:0] rt,
                      input logic rm, input logic gf, input logic ff);
    bit rdy, ret, pop, ok, mn;
    int p;
    logic [4:0] din;
    @(negedge Clk);
    AllocValid = av; AllocTag = at; ResolveValid = rv; ResolveTag = rt;
    ResolveMiss = rm; GlobalFlush = gf; FreeFull = ff;
    #1;
    rdy = mode == 0 && q.size() < 8;
    ret = mode == 0 && q.size() > 0 && q[0].done && !ff && !gf;
    pop = mode == 1 && !ff && !gf;
    din = pop ? q[q.size()-1].tag : ret ? q[0].tag : 5'd0;
    check("AllocReady", AllocReady, rdy);
    check("FreeWable", FreeWable, pop || ret);
    check("FreeDin", FreeDin, din);
    check("FreeClean", FreeClean, mode == 2);
    check("InflightCnt", InflightCnt, q.size());
    check("Busy", Busy, mode != 0);
    p = -1;
    foreach (q[i]) if (q[i].tag == rt) p = i;
    ok = rv && p >= 0 && (mode == 0 || p <= tgt);
    mn = ok && rm && (mode == 0 || p < tgt);
    if (gf) begin
      q.delete();
      mode = 2;
    end else begin
      if (ok) q[p].done = 1;
      if (mn) tgt = p;
      if (pop) void'(q.pop_back());
      if (ret) begin
        void'(q.pop_front());
        tgt--;
      end
      if (av && rdy) q.push_back('{at, 1'b0});
      if (mode == 2) mode = 0;
      else if (mode == 0 && mn && q.size() - 1 > tgt) mode = 1;
      else if (mode == 1 && pop && q.size() == tgt + 1) mode = 0;
    end
    @(posedge Clk);
  endtask
  task automatic push(input logic [4:0] t); step(1, t, 0, 0, 0, 0, 0); endtask
  task automatic res(input logic [4:0] t, input logic m); step(0, 0, 1, t, m, 0, 0); endtask
  task automatic idle(input logic ff); step(0, 0, 0, 0, 0, 0, ff); endtask
  task automatic reset_dut();
    @(negedge Clk);
    {AllocValid, ResolveValid, ResolveMiss, GlobalFlush, FreeFull} = '0;
    AllocTag = '0;
    ResolveTag = '0;
    Rest = 1;
    @(negedge Clk);
    Rest = 0;
    model_reset();
  endtask
  initial begin
    int cand[$];
    logic [4:0] rt;
    Rest = 1;
    {AllocValid, ResolveValid, ResolveMiss, GlobalFlush, FreeFull} = '0;
    AllocTag = '0;
    ResolveTag = '0;
    #3;
    check("rst_FreeWable", FreeWable, 0);
    check("rst_FreeDin", FreeDin, 0);
    check("rst_FreeClean", FreeClean, 0);
    check("rst_InflightCnt", InflightCnt, 0);
    check("rst_Busy", Busy, 0);
    @(negedge Clk);
    Rest = 0;
    model_reset();
    // in-order retire after out-of-order resolve
    push(1); push(5); push(9); res(5, 0); res(1, 0); idle(0); idle(0); idle(0);
    #1 check("req34_InflightCnt", InflightCnt, 1);
    // mispredict unwinds younger entries
    reset_dut();
    push(1); push(5); push(9); push(13); res(5, 1); idle(0); idle(0); idle(0);
    #1 check("req35_InflightCnt", InflightCnt, 2);
    // full ring, then retire frees a slot; head held by FreeFull
    reset_dut();
    for (int i = 0; i < 8; i++) push(5'(i));
    push(20); res(0, 0); idle(0); push(21);
    res(1, 0); idle(1); idle(1); idle(1); idle(0); idle(0);
    // global flush while unwinding
    reset_dut();
    for (int i = 0; i < 6; i++) push(5'(i + 2));
    step(0, 0, 1, 2, 1, 0, 1); idle(1); idle(1);
    step(0, 0, 0, 0, 0, 1, 1); idle(0); idle(0); idle(0);
    // asynchronous reset in the middle of an unwind
    reset_dut();
    push(3); push(4); push(6); push(7); res(3, 1); idle(1);
    @(negedge Clk);
    FreeFull = 0;
    #1 check("pre_rst_FreeWable", FreeWable, 1);
    #1 Rest = 1;
    #1;
    check("midrst_FreeWable", FreeWable, 0);
    check("midrst_FreeDin", FreeDin, 0);
    check("midrst_InflightCnt", InflightCnt, 0);
    check("midrst_Busy", Busy, 0);
    check("midrst_FreeClean", FreeClean, 0);
    @(negedge Clk);
    Rest = 0;
    model_reset();
    #1 check("post_rst_AllocReady", AllocReady, 1);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cand = {};
      foreach (q[i]) if (!q[i].done) cand.push_back(i);
      rt = (cand.size() > 0 && $urandom_range(0, 3) != 0) ? q[cand[$urandom_range(0, cand.size() - 1)]].tag : fresh();
      step($urandom_range(0, 1), fresh(), $urandom_range(0, 1), rt, $urandom_range(0, 3) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cbq_tag_recycler.md
CBQ_TAG_RECYCLER -- requirements
Module: cbq_tag_recycler

Interface
REQ-001 SHALL have parameter TAGWIDE, default 5, checkpoint tag width.
REQ-002 SHALL have parameter INFLDEEP, default 8, in-flight tag capacity (power of two).
REQ-003 Clk  in  1  sole clock, rising edge.
REQ-004 Rest  in  1  reset, asynchronous, active-high.
REQ-005 AllocValid  in  1  dispatch pushes a tag just read from the free queue.
REQ-006 AllocTag  in  TAGWIDE  the tag being pushed.
REQ-007 AllocReady  out  1  push accepted this cycle.
REQ-008 ResolveValid / ResolveTag / ResolveMiss  in  1/TAGWIDE/1  branch resolution; Miss=1 means mispredicted.
REQ-009 GlobalFlush  in  1  exception flush of all checkpoints.
REQ-010 FreeFull  in  1  free queue full.
REQ-011 FreeWable / FreeDin  out  1/TAGWIDE  return one tag to the free queue.
REQ-012 FreeClean  out  1  one-cycle pulse that re-initialises the free queue.
REQ-013 InflightCnt  out  log2(INFLDEEP)+1  live entries; Busy  out  1  state != RUN.

Function
REQ-014 SHALL hold an ordered ring (head=oldest, tail=next free), each entry {valid, tag, done}.
REQ-015 AllocReady SHALL be 1 iff state==RUN and count<INFLDEEP; accepted push writes {1,AllocTag,0} at tail, tail+1 mod INFLDEEP.
REQ-016 ResolveValid with tag matching a valid entry SHALL set its done bit next edge; no match or match on an entry being flushed SHALL be ignored.
REQ-017 Retire: when head valid and done, state RUN, and FreeFull=0, SHALL drive FreeWable=1 and FreeDin=head tag combinationally and advance head that edge; one retire per cycle max.
REQ-018 Resolve-to-return latency SHALL be one cycle for a head entry (done registered at edge N, FreeWable high in cycle N+1).
REQ-019 States: RUN, FLUSH, CLEAN.
REQ-020 RUN->FLUSH on accepted ResolveMiss; flush target = matched entry index; entries strictly younger are flushed.
REQ-021 FLUSH: each cycle with FreeFull=0, SHALL return tag at tail-1, clear it, decrement tail; ->RUN when tail==target+1 (zero cycles if no younger entries: stay RUN).
REQ-022 A ResolveMiss during FLUSH on an entry older than the current target SHALL move the target to it; younger or equal ignored.
REQ-023 Flush returns SHALL take priority over retire; retire stalls in FLUSH.
REQ-024 Push and retire in the same RUN cycle SHALL both occur; count unchanged.
REQ-025 GlobalFlush SHALL override all: clear every entry, head=tail=0, ->CLEAN; CLEAN pulses FreeClean=1 for exactly one cycle, FreeWable=0, then ->RUN.
REQ-026 FreeWable SHALL never be 1 while FreeFull=1 or in CLEAN.
REQ-027 Full ring (count==INFLDEEP) and empty ring SHALL be distinguished by count, not pointer equality; pointers wrap mod INFLDEEP.

Reset
REQ-028 Rest SHALL asynchronously clear all valid/done bits, head=tail=0, count=0, state=RUN.
REQ-029 During and after reset: AllocReady=1 (after release), FreeWable=0, FreeDin=0, FreeClean=0, InflightCnt=0, Busy=0.
REQ-030 Reset mid-FLUSH SHALL abandon the flush with no further returns; free queue re-initialisation is the owner's responsibility.

Configuration
REQ-031 Macro CBQ_RECYCLE_PERF_EN: when defined, SHALL add 16-bit saturating outputs PerfRetireCnt and PerfFlushCnt counting retire and flush returns, cleared by Rest; when undefined, ports and logic SHALL be absent.

Structure
REQ-032 Shared package SHALL hold TAGWIDE/INFLDEEP defaults and the RUN/FLUSH/CLEAN state encoding.
REQ-033 One sub-module cbq_tag_cam SHALL perform tag-to-index match over valid entries, returning hit and index.

Verification
REQ-034 Push tags 1,5,9; resolve 5 then 1 -> FreeDin=1 then 5 on consecutive cycles after the second resolve; 9 stays, InflightCnt=1.
REQ-035 Push 1,5,9,13; ResolveMiss tag 5 -> Busy=1, FreeDin=13 then 9, AllocReady=0 for 2 cycles, InflightCnt=2.
REQ-036 Push 8 tags -> AllocReady=0, InflightCnt=8; retire head -> AllocReady=1 next cycle.
REQ-037 Head done with FreeFull=1 for 3 cycles -> FreeWable=0 for 3 cycles, returns in cycle FreeFull drops.
REQ-038 GlobalFlush with 6 live entries in FLUSH -> FreeClean high exactly 1 cycle, InflightCnt=0, no FreeWable.
REQ-039 Assert Rest mid-FLUSH -> outputs zero immediately without clock edge; AllocReady=1 after release.
